reg_read_scoreboard: RTL and testbench

- Read-side counterpart to the write-register select path: a register file with two read ports, one write-back port and a per-register pending scoreboard.
- Accepts an instruction's source and destination register numbers at issue, stalls on unresolved hazards, and presents registered operands one cycle later.
- The destination arriving on dest_addr is the already-selected write register (RegDst choice made upstream).
- Sits between decode and execute; write-back comes from the end of the pipeline.

---
 rtl/reg_read_scoreboard.sv | 128 ++++++++++++
 tb/tb_reg_read_scoreboard.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_scoreboard.sv
// Register file with two read ports and one write-back port. A per-register
// pending bit tracks producers that are still in flight. Decode offers an
// instruction; it is accepted only when no source or destination is pending
// (unless the pending value arrives on write-back this very cycle). The
// accepted operands are presented one cycle later, held until execute takes them.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both high. Ready is combinational and never depends on valid.
// The offering side may change its offer at any time before the transfer.
// Once op_valid is high, the op_* and data outputs stay frozen until op_ready
// is seen high.
module reg_read_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic [ADDR_W-1:0]     rs_addr,
   input  logic [ADDR_W-1:0]     rt_addr,
   input  logic                  use_rt,
   input  logic [ADDR_W-1:0]     dest_addr,
   input  logic                  dest_en,
   input  logic                  wb_valid,
   input  logic [ADDR_W-1:0]     wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [DATA_W-1:0]     rs_data,
   output logic [DATA_W-1:0]     rt_data,
   output logic [ADDR_W-1:0]     op_dest,
   output logic                  op_dest_en,
   output logic [(2**ADDR_W)-1:0] busy
);

   localparam int NREGS = 2**ADDR_W;

   logic [DATA_W-1:0] regFile [NREGS];
   logic [NREGS-1:0]  busyQ;
   logic [NREGS-1:0]  busyNext;

   logic              wbWrite;
   logic              rsHit, rtHit, destHit;
   logic              rsOk, rtOk, destOk;
   logic              hazard;
   logic              accept;
   logic [DATA_W-1:0] rsFwd, rtFwd;

   assign busy = busyQ;

   // Hazard detection, same-cycle bypass and the issue-side handshake.
   always_comb begin
      wbWrite  = wb_valid && (wb_addr != '0);
      rsHit    = wbWrite && (wb_addr == rs_addr);
      rtHit    = wbWrite && (wb_addr == rt_addr);
      destHit  = wbWrite && (wb_addr == dest_addr);
      // busyQ[0] is never set, so register 0 is always ok.
      rsOk     = !busyQ[rs_addr]   || rsHit;
      rtOk     = !busyQ[rt_addr]   || rtHit;
      destOk   = !busyQ[dest_addr] || destHit;
      // The destination term is the WAW stall: never let two producers of
      // the same register be in flight at once.
      hazard   = !rsOk || (use_rt && !rtOk) || (dest_en && !destOk);
      issue_ready = !hazard && (!op_valid || op_ready);
      accept   = issue_valid && issue_ready;
      // Register 0 is never written, so the array copy already reads as zero.
      rsFwd    = rsHit ? wb_data : regFile[rs_addr];
      rtFwd    = '0;
      if (use_rt) begin
         rtFwd = rtHit ? wb_data : regFile[rt_addr];
      end
   end

   // Next pending vector: write-back clears first, a new producer sets after,
   // so a set and clear of the same register leaves it pending.
   always_comb begin
      busyNext = busyQ;
      if (wbWrite) begin
         busyNext[wb_addr] = 1'b0;
      end
      if (accept && dest_en && (dest_addr != '0)) begin
         busyNext[dest_addr] = 1'b1;
      end
      busyNext[0] = 1'b0;
   end

   // Register array: write-back lands regardless of the pending bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regFile[i] <= '0;
         end
      end else if (wbWrite) begin
         regFile[wb_addr] <= wb_data;
      end
   end

   // Pending scoreboard.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busyQ <= '0;
      end else begin
         busyQ <= busyNext;
      end
   end

   // Operand bundle register: loads on accept, drops valid when consumed
   // without a replacement; data keeps its last value once valid falls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_valid   <= 1'b0;
         rs_data    <= '0;
         rt_data    <= '0;
         op_dest    <= '0;
         op_dest_en <= 1'b0;
      end else if (accept) begin
         op_valid   <= 1'b1;
         rs_data    <= rsFwd;
         rt_data    <= rtFwd;
         op_dest    <= dest_addr;
         op_dest_en <= dest_en;
      end else if (op_ready) begin
         op_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Bench for reg_read_scoreboard: a reference model of the register file and
// pending bits predicts issue_ready, busy and each operand bundle; bundles go
// into an expected queue on issue and are compared when execute takes them.
module tb_reg_read_scoreboard;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREGS  = 2**ADDR_W;
   localparam int BW     = 2*DATA_W + ADDR_W + 1;

   logic              clk;
   logic              reset_n;
   logic              issue_valid;
   logic              issue_ready;
   logic [ADDR_W-1:0] rs_addr, rt_addr, dest_addr;
   logic              use_rt, dest_en;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              op_valid, op_ready;
   logic [DATA_W-1:0] rs_data, rt_data;
   logic [ADDR_W-1:0] op_dest;
   logic              op_dest_en;
   logic [NREGS-1:0]  busy;

   int checks   = 0;
   int failures = 0;

   logic [BW-1:0]     exp_q[$];
   logic [DATA_W-1:0] refRegs [NREGS];
   logic [NREGS-1:0]  refBusy;
   logic              refOpValid;

   reg_read_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .use_rt(use_rt),
      .dest_addr(dest_addr), .dest_en(dest_en),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .op_valid(op_valid), .op_ready(op_ready),
      .rs_data(rs_data), .rt_data(rt_data),
      .op_dest(op_dest), .op_dest_en(op_dest_en), .busy(busy)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Consumer-side scoreboard: a bundle transfers when valid and ready meet.
   always @(negedge clk) begin
      if (reset_n && op_valid && op_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL bundle_unexpected got rs=%h rt=%h dest=%0d en=%b, none expected",
                     rs_data, rt_data, op_dest, op_dest_en);
         end else begin
            logic [BW-1:0] e;
            e = exp_q.pop_front();
            if ({rs_data, rt_data, op_dest, op_dest_en} !== e) begin
               failures++;
               $display("FAIL bundle got rs=%h rt=%h dest=%0d en=%b exp rs=%h rt=%h dest=%0d en=%b",
                        rs_data, rt_data, op_dest, op_dest_en,
                        e[BW-1 -: DATA_W], e[DATA_W+ADDR_W -: DATA_W],
                        e[ADDR_W:1], e[0]);
            end
         end
      end
   end

   function automatic logic srcOk(input logic [ADDR_W-1:0] r);
      return !refBusy[r] || (wb_valid && wb_addr == r && r != '0);
   endfunction

   function automatic logic [DATA_W-1:0] rdModel(input logic [ADDR_W-1:0] r);
      if (r == '0) return '0;
      if (wb_valid && wb_addr == r) return wb_data;
      return refRegs[r];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NREGS; i++) refRegs[i] = '0;
      refBusy    = '0;
      refOpValid = 1'b0;
      exp_q.delete();
   endtask

   task automatic setIdle();
      issue_valid = 0; rs_addr = 0; rt_addr = 0; use_rt = 0;
      dest_addr = 0; dest_en = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
      op_ready = 1;
   endtask

   task automatic setIssue(input int rs, input int rt, input logic ur,
                           input int dst, input logic den);
      issue_valid = 1; rs_addr = ADDR_W'(rs); rt_addr = ADDR_W'(rt);
      use_rt = ur; dest_addr = ADDR_W'(dst); dest_en = den;
   endtask

   // One clock: check the handshake and pending bits against the model,
   // record the expected bundle on accept, advance the model over the edge.
   // expReady < 0 means no fixed expectation beyond the model.
   task automatic step(input int expReady);
      logic mReady, acc;
      logic [DATA_W-1:0] rsE, rtE;
      @(negedge clk);
      mReady = srcOk(rs_addr) && (!use_rt || srcOk(rt_addr)) &&
               (!dest_en || srcOk(dest_addr)) && (!refOpValid || op_ready);
      checks++;
      if (issue_ready !== mReady) begin
         failures++;
         $display("FAIL issue_ready_model got %b exp %b", issue_ready, mReady);
      end
      if (expReady >= 0) begin
         checks++;
         if (issue_ready !== expReady[0]) begin
            failures++;
            $display("FAIL issue_ready_fixed got %b exp %b", issue_ready, expReady[0]);
         end
      end
      checks++;
      if (busy !== refBusy) begin
         failures++;
         $display("FAIL busy got %h exp %h", busy, refBusy);
      end
      acc = issue_valid && mReady;
      if (acc) begin
         rsE = rdModel(rs_addr);
         rtE = use_rt ? rdModel(rt_addr) : '0;
         exp_q.push_back({rsE, rtE, dest_addr, dest_en});
      end
      if (acc) refOpValid = 1'b1;
      else if (op_ready) refOpValid = 1'b0;
      if (wb_valid && wb_addr != '0) begin
         refRegs[wb_addr] = wb_data;
         refBusy[wb_addr] = 1'b0;
      end
      if (acc && dest_en && dest_addr != '0) refBusy[dest_addr] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      setIdle();
      reset_n = 1'b0;
      modelReset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if ({op_valid, busy, rs_data, rt_data, op_dest, op_dest_en} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b busy=%h rs=%h rt=%h dest=%0d en=%b exp all 0",
                  op_valid, busy, rs_data, rt_data, op_dest, op_dest_en);
      end
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
      step(1);
   endtask

   task automatic test_basic();
      setIssue(3, 4, 1, 5, 1);
      step(1);
      setIdle();
      checks++;
      if (op_valid !== 1'b1 || rs_data !== '0 || rt_data !== '0 ||
          op_dest !== 5'd5 || busy[5] !== 1'b1) begin
         failures++;
         $display("FAIL basic got v=%b rs=%h rt=%h dest=%0d busy5=%b exp v=1 rs=0 rt=0 dest=5 busy5=1",
                  op_valid, rs_data, rt_data, op_dest, busy[5]);
      end
      step(1);
   endtask

   task automatic test_raw_bypass();
      setIssue(5, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0);
      wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
      step(1);
      setIdle();
      checks++;
      if (rs_data !== 32'hDEADBEEF || busy[5] !== 1'b0) begin
         failures++;
         $display("FAIL raw_bypass got rs=%h busy5=%b exp rs=deadbeef busy5=0", rs_data, busy[5]);
      end
      step(1);
   endtask

   task automatic test_waw();
      setIssue(1, 2, 1, 7, 1);
      step(1);
      step(0);
      step(0);
      wb_valid = 1; wb_addr = 7; wb_data = 32'h77;
      step(1);
      setIdle();
      checks++;
      if (busy[7] !== 1'b1) begin
         failures++;
         $display("FAIL waw_set_wins got busy7=%b exp 1", busy[7]);
      end
      wb_valid = 1; wb_addr = 7; wb_data = 32'h88;
      step(1);
      setIdle();
      step(1);
   endtask

   task automatic test_reg0();
      wb_valid = 1; wb_addr = 0; wb_data = 32'h1234;
      step(1);
      setIdle();
      setIssue(0, 0, 1, 0, 1);
      step(1);
      setIdle();
      checks++;
      if (rs_data !== '0 || rt_data !== '0 || busy !== '0) begin
         failures++;
         $display("FAIL reg0 got rs=%h rt=%h busy=%h exp rs=0 rt=0 busy=0", rs_data, rt_data, busy);
      end
      step(1);
   endtask

   task automatic test_hold();
      wb_valid = 1; wb_addr = 1; wb_data = 32'hA5A50001;
      step(1);
      setIdle();
      setIssue(1, 1, 1, 9, 1);
      step(1);
      op_ready = 0;
      setIssue(2, 0, 0, 10, 1);
      for (int i = 0; i < 3; i++) begin
         step(0);
         checks++;
         if (op_valid !== 1'b1 || rs_data !== 32'hA5A50001 || rt_data !== 32'hA5A50001 ||
             op_dest !== 5'd9 || op_dest_en !== 1'b1) begin
            failures++;
            $display("FAIL hold got v=%b rs=%h rt=%h dest=%0d en=%b exp v=1 rs=a5a50001 rt=a5a50001 dest=9 en=1",
                     op_valid, rs_data, rt_data, op_dest, op_dest_en);
         end
      end
      op_ready = 1;
      step(1);
      setIdle();
      checks++;
      if (op_valid !== 1'b1 || op_dest !== 5'd10) begin
         failures++;
         $display("FAIL back_to_back got v=%b dest=%0d exp v=1 dest=10", op_valid, op_dest);
      end
      step(-1);
      wb_valid = 1; wb_addr = 9; wb_data = 32'h9;
      step(-1);
      wb_addr = 10; wb_data = 32'hA;
      step(-1);
      setIdle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 200; i++) begin
         issue_valid = ($urandom_range(0, 3) != 0);
         rs_addr     = ADDR_W'($urandom_range(0, 7));
         rt_addr     = ADDR_W'($urandom_range(0, 7));
         use_rt      = $urandom_range(0, 1) == 1;
         dest_addr   = ADDR_W'($urandom_range(0, 7));
         dest_en     = $urandom_range(0, 1) == 1;
         wb_valid    = $urandom_range(0, 1) == 1;
         wb_addr     = ADDR_W'($urandom_range(0, 7));
         wb_data     = $urandom;
         op_ready    = ($urandom_range(0, 3) != 0);
         step(-1);
      end
      setIdle();
      step(-1);
      step(-1);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending bundles exp 0", exp_q.size());
      end
   endtask

   task automatic test_async_reset();
      wb_valid = 1; wb_addr = 3; wb_data = 32'hCAFE0003;
      step(-1);
      setIdle();
      op_ready = 0;
      setIssue(3, 3, 1, 12, 1);
      step(1);
      setIdle();
      op_ready = 0;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (op_valid !== 1'b0 || busy !== '0 || rs_data !== '0 || rt_data !== '0 ||
          op_dest !== '0 || op_dest_en !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got v=%b busy=%h rs=%h rt=%h dest=%0d en=%b exp all 0",
                  op_valid, busy, rs_data, rt_data, op_dest, op_dest_en);
      end
      modelReset();
      op_ready = 1;
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
      setIssue(3, 0, 0, 0, 0);
      step(1);
      setIdle();
      checks++;
      if (rs_data !== '0) begin
         failures++;
         $display("FAIL reset_clears_regs got rs=%h exp 0", rs_data);
      end
      step(-1);
   endtask

   initial begin
      reset_n = 1'b0;
      setIdle();
      test_reset();
      test_basic();
      test_raw_bypass();
      test_waw();
      test_reg0();
      test_hold();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
